// File: rtl/rv32im_bus_arbiter.sv
// rv32im_bus_arbiter
// -----------------------------------------------------------------------------
// N-master Wishbone arbiter and bus multiplexer. A registered one-hot grant
// selects which master drives the single system bus. The bus-side mux and the
// ack/err routing are combinational from that registered grant.
//
// Optional feature macro: RV32IM_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin winner search starting after the last winner
//   undefined -> fixed priority, master 0 highest
//
// Parameters:
//   NUM_MASTERS  number of requesters (2..8), index 0 highest fixed priority
//   XLEN         data width; the word address is XLEN-2 bits
//   MAX_HOLD     tenure in cycles after which an idle owner may be preempted
//                (0 disables preemption)
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_i / grant_o         per-master level request / registered grant
//   m_adr_i, m_dat_i,       flattened master-side bus signals, master i at
//   m_sel_i                 slice i
//   m_cyc_i/m_stb_i/m_we_i  per-master cycle, strobe, write enable
//   m_ack_o, m_err_o        per-master ack/err, only the owner sees them
//   m_dat_o                 read data broadcast to all masters
//   adr_o ... we_o          system-bus outputs driven by the owner (0 if none)
//   dat_i, ack_i, err_i     system-bus inputs
// -----------------------------------------------------------------------------
module rv32im_bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int XLEN        = 32,
  parameter int MAX_HOLD    = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_MASTERS-1:0]      req_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  input  logic [NUM_MASTERS*(XLEN-2)-1:0] m_adr_i,
  input  logic [NUM_MASTERS*XLEN-1:0] m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]    m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [XLEN-1:0]             m_dat_o,
  output logic [XLEN-3:0]             adr_o,
  output logic [XLEN-1:0]             dat_o,
  output logic [3:0]                  sel_o,
  output logic                        cyc_o,
  output logic                        stb_o,
  output logic                        we_o,
  input  logic [XLEN-1:0]             dat_i,
  input  logic                        ack_i,
  input  logic                        err_i
);

  localparam int AW = XLEN - 2;
  // A zero-width counter is illegal, so keep one bit when preemption is off.
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, OWNED} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [NUM_MASTERS-1:0] cand;
  logic [NUM_MASTERS-1:0] win;
  logic                   owner_req, owner_cyc, others_req, preempt;

  assign cand       = req_i & ~mask_q;
  assign owner_req  = |(req_i & grant_q);
  assign owner_cyc  = |(m_cyc_i & grant_q);
  assign others_req = |(req_i & ~grant_q);
  // Only cut a tenure between transactions, never while the owner holds cyc.
  assign preempt    = (MAX_HOLD != 0) && (hold_q >= HW'(MAX_HOLD)) &&
                      others_req && !owner_cyc;

`ifdef RV32IM_ARB_ROUND_ROBIN_EN
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  logic [IW-1:0] rr_q, rr_d, win_idx;

  // Search starts one past the previous winner and wraps around.
  always_comb begin
    int  idx;
    logic found;
    win     = '0;
    win_idx = rr_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(rr_q) + k) % NUM_MASTERS;
      if (!found && cand[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = IW'(idx);
      end
    end
  end
`else
  // Descending scan so the lowest requesting index is the last one written.
  always_comb begin
    win = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    mask_d  = mask_q;
    hold_d  = hold_q;
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        // The mask only ever applies to a single arbitration decision.
        mask_d = '0;
        if (|cand) begin
          grant_d = win;
          hold_d  = '0;
          state_d = OWNED;
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
          rr_d    = win_idx;
`endif
        end
      end
      OWNED: begin
        if (!owner_req) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (preempt) begin
          grant_d = '0;
          mask_d  = grant_q;
          state_d = IDLE;
        end else if (hold_q < HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      mask_q  <= '0;
      hold_q  <= '0;
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
      rr_q    <= IW'(NUM_MASTERS - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      mask_q  <= mask_d;
      hold_q  <= hold_d;
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign grant_o = grant_q;
  assign m_dat_o = dat_i;

  // Grant is one-hot or zero, so OR-ing the gated slices forms the mux and
  // yields all zeros when nobody owns the bus.
  always_comb begin
    adr_o = '0;
    dat_o = '0;
    sel_o = '0;
    cyc_o = 1'b0;
    stb_o = 1'b0;
    we_o  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        adr_o = adr_o | m_adr_i[i*AW +: AW];
        dat_o = dat_o | m_dat_i[i*XLEN +: XLEN];
        sel_o = sel_o | m_sel_i[i*4 +: 4];
        cyc_o = cyc_o | m_cyc_i[i];
        stb_o = stb_o | m_stb_i[i];
        we_o  = we_o  | m_we_i[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_route
      assign m_ack_o[gi] = ack_i & grant_q[gi];
      assign m_err_o[gi] = err_i & grant_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// Testbench for rv32im_bus_arbiter: directed scenarios plus a randomized run,
// all checked against a tenure-level reference model (owner index, hold
// count, masked master, last winner).
module tb_rv32im_bus_arbiter;
  localparam int N    = 3;
  localparam int XLEN = 32;
  localparam int AW   = XLEN - 2;
  localparam int MAXH = 8;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [N-1:0]      req, grant_o;
  logic [N*AW-1:0]   m_adr;
  logic [N*XLEN-1:0] m_dat;
  logic [N*4-1:0]    m_sel;
  logic [N-1:0]      m_cyc, m_stb, m_we, m_ack_o, m_err_o;
  logic [XLEN-1:0]   m_dat_o, dat_o, dat_i;
  logic [AW-1:0]     adr_o;
  logic [3:0]        sel_o;
  logic              cyc_o, stb_o, we_o, ack_i, err_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32im_bus_arbiter #(.NUM_MASTERS(N), .XLEN(XLEN), .MAX_HOLD(MAXH)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req), .grant_o(grant_o),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  // ---------------- reference model ----------------
  int mo_owner = -1;   // -1: bus free
  int mo_hold  = 0;
  int mo_mask  = -1;   // master excluded from the next decision
  int mo_rr    = N - 1;

  function automatic int pick(logic [N-1:0] c, int rr);
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) if (c[(rr + k) % N]) return (rr + k) % N;
`else
    for (int i = 0; i < N; i++) if (c[i]) return i;
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (mo_owner >= 0) g[mo_owner] = 1'b1;
    return g;
  endfunction

  always @(posedge clk) begin : model
    int o, h, mk, r, w;
    logic [N-1:0] c, others;
    o = mo_owner; h = mo_hold; mk = mo_mask; r = mo_rr;
    if (reset_i) begin
      o = -1; h = 0; mk = -1; r = N - 1;
    end else if (o < 0) begin
      c = req;
      if (mk >= 0) c[mk] = 1'b0;
      mk = -1;
      w = pick(c, r);
      if (w >= 0) begin o = w; h = 0; r = w; end
    end else begin
      others = req;
      others[o] = 1'b0;
      if (!req[o]) o = -1;
      else if (h >= MAXH && others != 0 && !m_cyc[o]) begin mk = o; o = -1; end
      else if (h < MAXH) h = h + 1;
    end
    mo_owner <= o; mo_hold <= h; mo_mask <= mk; mo_rr <= r;
  end

  // ---------------- scenarios ----------------
  task automatic idle_inputs();
    req = '0; m_cyc = '0; m_stb = '0; m_we = '0; ack_i = 0; err_i = 0;
  endtask

  task automatic test_reset();
    reset_i = 1; req = 3'b111; m_cyc = 3'b111; m_stb = 3'b111;
    m_adr = '1; m_dat = '1; m_sel = '1; m_we = '1; dat_i = '0; ack_i = 1; err_i = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (grant_o !== 3'b000 || cyc_o !== 1'b0 || adr_o !== '0 || m_ack_o !== '0 || m_err_o !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d grant=%b cyc=%b adr=%h ack=%b err=%b required all zero",
                 i, grant_o, cyc_o, adr_o, m_ack_o, m_err_o);
      end
    end
    reset_i = 0; ack_i = 0; err_i = 0;
    @(negedge clk);
    checks++;
    if (grant_o !== 3'b001) begin
      failures++;
      $display("FAIL reset_first_grant got=%b required=001", grant_o);
    end
    $display("test_reset: first grant %b", grant_o);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    logic [N-1:0] seq [4];
    logic [N-1:0] want [4];
    want[0] = 3'b010; want[1] = 3'b010; want[2] = 3'b000; want[3] = 3'b100;
    req = 3'b110; m_cyc = 3'b110;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seq[i] = grant_o;
      if (i == 1) req = 3'b100;
      checks++;
      if (grant_o !== want[i] || grant_o !== exp_grant()) begin
        failures++;
        $display("FAIL priority_seq step=%0d got=%b required=%b model=%b", i, grant_o, want[i], exp_grant());
      end
    end
    $display("test_fixed_priority: %b %b %b %b", seq[0], seq[1], seq[2], seq[3]);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    req = 3'b001; m_cyc = 3'b001;
    repeat (2) @(negedge clk);
    req = 3'b110; m_cyc = 3'b110;   // release and new requests together
    @(negedge clk);
    checks++;
    if (grant_o !== 3'b000) begin
      failures++;
      $display("FAIL b2b_dead_cycle got=%b required=000", grant_o);
    end
    @(negedge clk);
    checks++;
    if (grant_o !== exp_grant() || grant_o === 3'b000) begin
      failures++;
      $display("FAIL b2b_next_grant got=%b required=%b", grant_o, exp_grant());
    end
    $display("test_back_to_back: dead cycle then %b", grant_o);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rotation();
    logic [N-1:0] seq [$];
    int held = 0;
    req = 3'b111; m_cyc = 3'b111;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (grant_o !== exp_grant()) begin
        failures++;
        $display("FAIL rotation cycle=%0d got=%b required=%b", i, grant_o, exp_grant());
      end
      if (grant_o != 0 && (seq.size() == 0 || held == 0)) seq.push_back(grant_o);
      req = 3'b111;
      if (mo_owner >= 0) begin
        held++;
        if (held == 4) begin req[mo_owner] = 1'b0; held = 0; end
      end
    end
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
    checks++;
    if (seq.size() < 4 || seq[0] !== 3'b001 || seq[1] !== 3'b010 || seq[2] !== 3'b100 || seq[3] !== 3'b001) begin
      failures++;
      $display("FAIL rr_sequence got=%p required=001,010,100,001", seq);
    end
`endif
    $display("test_rotation: %0d tenures observed", seq.size());
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_preemption();
    int own0 = 0;
    int state = 0;   // 0: owned by 0, 1: saw dead cycle, 2: saw master 2
    req = 3'b001;
    for (int i = 0; i < 30; i++) begin
      m_cyc[0] = (i % 3) != 0;
      if (i >= 3) req[2] = 1'b1;
      @(negedge clk);
      checks++;
      if (grant_o !== exp_grant()) begin
        failures++;
        $display("FAIL preempt_model cycle=%0d got=%b required=%b", i, grant_o, exp_grant());
      end
      if (state == 0 && grant_o == 3'b001) own0++;
      else if (state == 0 && own0 > 0 && grant_o == 3'b000) state = 1;
      else if (state == 1) begin
        state = 2;
        checks++;
        if (grant_o !== 3'b100) begin
          failures++;
          $display("FAIL preempt_next got=%b required=100", grant_o);
        end
      end
    end
    checks++;
    if (state != 2 || own0 < MAXH + 1) begin
      failures++;
      $display("FAIL preempt_tenure owned_cycles=%0d phase=%0d required>=%0d phase=2", own0, state, MAXH + 1);
    end
    $display("test_preemption: master0 held %0d cycles", own0);
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ack_isolation();
    req = 3'b010; m_cyc = 3'b010; m_stb = 3'b010;
    m_adr = {30'h0AAAAAAA, 30'h01234567, 30'h15555555};
    @(negedge clk);
    ack_i = 1; m_cyc = 3'b011;
    #1;
    checks++;
    if (m_ack_o !== 3'b010 || cyc_o !== 1'b1 || adr_o !== 30'h01234567) begin
      failures++;
      $display("FAIL ack_route ack=%b cyc=%b adr=%h required ack=010 cyc=1 adr=01234567", m_ack_o, cyc_o, adr_o);
    end
    @(negedge clk);
    ack_i = 0; err_i = 1; m_cyc = 3'b001;
    #1;
    checks++;
    if (m_err_o !== 3'b010 || m_ack_o !== 3'b000 || cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL err_route err=%b ack=%b cyc=%b required err=010 ack=000 cyc=0", m_err_o, m_ack_o, cyc_o);
    end
    $display("test_ack_isolation: ack/err routed to owner only");
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req = 3'b100; m_cyc = 3'b100; m_stb = 3'b100;
    repeat (2) @(negedge clk);
    reset_i = 1;
    @(negedge clk);
    ack_i = 1;
    #1;
    checks++;
    if (m_ack_o !== 3'b000 || grant_o !== 3'b000 || cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid ack=%b grant=%b cyc=%b required 000/000/0", m_ack_o, grant_o, cyc_o);
    end
    $display("test_reset_mid: grant=%b ack=%b", grant_o, m_ack_o);
    reset_i = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [AW-1:0]   e_adr;
    logic [XLEN-1:0] e_dat;
    logic [3:0]      e_sel;
    logic [2:0]      e_ctl;
    logic [N-1:0]    e_g;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      m_cyc = N'($urandom); m_stb = N'($urandom); m_we = N'($urandom);
      m_adr = {$urandom, $urandom, $urandom};
      m_dat = {$urandom, $urandom, $urandom};
      m_sel = N*4'($urandom);
      dat_i = $urandom; ack_i = 1'($urandom); err_i = 1'($urandom);
      reset_i = ($urandom_range(0, 299) == 0);
      #1;
      e_g = exp_grant();
      e_adr = '0; e_dat = '0; e_sel = '0; e_ctl = '0;
      if (mo_owner >= 0) begin
        e_adr = m_adr[mo_owner*AW +: AW];
        e_dat = m_dat[mo_owner*XLEN +: XLEN];
        e_sel = m_sel[mo_owner*4 +: 4];
        e_ctl = {m_cyc[mo_owner], m_stb[mo_owner], m_we[mo_owner]};
      end
      checks++;
      if (grant_o !== e_g) begin
        failures++;
        $display("FAIL rnd_grant cycle=%0d got=%b required=%b", i, grant_o, e_g);
      end
      checks++;
      if (adr_o !== e_adr || dat_o !== e_dat || sel_o !== e_sel || {cyc_o, stb_o, we_o} !== e_ctl) begin
        failures++;
        $display("FAIL rnd_mux cycle=%0d got adr=%h dat=%h sel=%h ctl=%b required adr=%h dat=%h sel=%h ctl=%b",
                 i, adr_o, dat_o, sel_o, {cyc_o, stb_o, we_o}, e_adr, e_dat, e_sel, e_ctl);
      end
      checks++;
      if (m_ack_o !== (ack_i ? e_g : '0) || m_err_o !== (err_i ? e_g : '0) || m_dat_o !== dat_i) begin
        failures++;
        $display("FAIL rnd_route cycle=%0d ack=%b err=%b mdat=%h required ack=%b err=%b mdat=%h",
                 i, m_ack_o, m_err_o, m_dat_o, ack_i ? e_g : '0, err_i ? e_g : '0, dat_i);
      end
    end
    $display("test_random: 3000 cycles compared");
    reset_i = 0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_back_to_back();
    test_rotation();
    test_preemption();
    test_ack_isolation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv32im_bus_arbiter.md
# rv32im_bus_arbiter

N-master Wishbone bus arbiter and multiplexer; the parametrised successor to the fixed three-way priority arbiter embedded in the no-pipe core. It sits between the core's requesters (memory stage, prefetch, external controller, DMA) and the single system bus. It adds generic master count, optional round-robin fairness and bounded bus tenure with preemption at transaction boundaries.

## Interface
- NUM_MASTERS, 3, number of requesting masters (2..8); index 0 is highest fixed priority
- XLEN, 32, data width; address width is XLEN-2 (word address)
- MAX_HOLD, 0, tenure limit in cycles before preemption is allowed; 0 disables preemption
- clk_i  input  1  system clock
- reset_i  input  1  synchronous, active-high reset
- req_i  input  NUM_MASTERS  per-master bus request (ctrl_req), level, held for whole tenure
- grant_o  output  NUM_MASTERS  one-hot (or zero) registered grant (ctrl_grant)
- m_adr_i  input  NUM_MASTERS*(XLEN-2)  flattened master addresses, master i at slice i
- m_dat_i  input  NUM_MASTERS*XLEN  flattened master write data
- m_sel_i  input  NUM_MASTERS*4  flattened byte selects
- m_cyc_i / m_stb_i / m_we_i  input  NUM_MASTERS each  per-master cycle, strobe, write enable
- m_ack_o / m_err_o  output  NUM_MASTERS each  per-master ack / err
- m_dat_o  output  XLEN  read data broadcast to all masters
- adr_o  output  XLEN-2 ; dat_o  output  XLEN ; sel_o  output  4 ; cyc_o, stb_o, we_o  output  1  bus side
- dat_i  input  XLEN ; ack_i, err_i  input  1  bus side

## Operation
- FSM states: IDLE (grant_o = 0), OWNED (exactly one grant bit set).
- IDLE: if any unmasked req_i set, pick winner, load grant_o, clear hold_cnt, go OWNED. Else stay.
- OWNED: if req_i[owner] = 0 -> grant_o = 0, go IDLE. Preemption (MAX_HOLD != 0): hold_cnt >= MAX_HOLD and any other req_i set and m_cyc_i[owner] = 0 -> grant_o = 0, set mask bit for owner, go IDLE.
- hold_cnt: width $clog2(MAX_HOLD+1), increments each OWNED cycle, saturates at MAX_HOLD.
- Mask: preempted master excluded from the next single arbitration decision only; mask cleared when that decision is made (even if no winner). If only the masked master requests, it is regranted one cycle later.
- Bus mux: with grant bit i set, adr_o/dat_o/sel_o/cyc_o/stb_o/we_o = master i slice. With grant_o = 0: all bus outputs 0.
- m_ack_o[i] = ack_i & grant_o[i]; m_err_o[i] = err_i & grant_o[i]; m_dat_o = dat_i unconditionally.
- Masters that drive cyc without grant are ignored; acks never reach non-owners.

## Timing
- Reset: grant_o = 0, state IDLE, hold_cnt = 0, mask = 0, rr pointer = NUM_MASTERS-1; all bus outputs 0, m_ack_o/m_err_o = 0 the cycle after reset asserts.
- Grant latency: req_i rises edge t, IDLE -> grant_o at t+1.
- Release: req_i[owner] falls at t -> grant_o = 0 at t+1 -> next grant at t+2 (one dead cycle mandatory between owners).
- Simultaneous release and new requests: dead cycle still inserted.
- Preemption evaluated only when owner's m_cyc_i is low; a transaction in flight is never cut.
- Reset mid-transaction: grant dropped at next edge; in-flight ack_i discarded.
- Mux and ack routing are combinational from registered grant_o; no added latency.

## Configuration
- RV32IM_ARB_ROUND_ROBIN_EN defined: winner = first requesting unmasked master searching from (rr pointer + 1) mod NUM_MASTERS upward with wrap; rr pointer updated to winner on each grant.
- Undefined: fixed priority, lowest index wins; rr pointer unused (removed).

## Test plan
- Reset: assert reset_i 2 cycles with req_i = 3'b111 -> grant_o = 0, cyc_o = 0 during reset; first grant 3'b001 one cycle after release.
- Fixed priority, NUM_MASTERS=3: req_i = 3'b110 at t -> grant_o = 3'b010 at t+1; drop req_i[1] -> 3'b000 then 3'b100.
- Round robin (macro on): all three hold req, each releases after 4 cycles and re-requests -> grant sequence 001, 010, 100, 001 with one zero cycle between.
- Preemption MAX_HOLD=8: master 0 holds req with cyc pulses, master 2 requests at cycle 3 -> master 0 keeps grant until hold_cnt = 8 and m_cyc_i[0] = 0, then grant 000, then 100.
- Ack isolation: master 1 owns, ack_i = 1 -> m_ack_o = 3'b010; err_i = 1 -> m_err_o = 3'b010; master 0 asserting m_cyc_i sees no effect on cyc_o.
- Reset mid-transaction: reset_i during owned cycle with ack_i = 1 next cycle -> m_ack_o = 0, grant_o = 0.
